// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter. It honours fixed-length bursts and locked sequences,
// and registers hgrant/hmaster/hmastlock for the address/data muxes and decoder.
`timescale 1ns/1ps
module ahb_rr_arbiter #(
  parameter int NM             = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NM)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [NM-1:0] hbusreq,
  input  logic [NM-1:0] hlock,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hburst,
  input  logic          hready,
  output logic [NM-1:0] hgrant,
  output logic [MW-1:0] hmaster,
  output logic          hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam int IW = MW + 1;
  localparam logic [MW-1:0] DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [NM-1:0] DEF_GRANT = NM'(1) << DEFAULT_MASTER;

  logic [MW-1:0] owner_reg, owner_next;
  logic [MW-1:0] ptr_reg, ptr_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [3:0]    burst_load;
  logic [NM-1:0] grant_next;
  logic [MW-1:0] rr_winner;
  logic [MW-1:0] rr_idx;
  logic [IW-1:0] rr_sum;
  logic          rr_found;
  logic          locked_hold;
  logic          window;

  // Remaining beats after the first one; SINGLE and INCR have no fixed tail.
  always_comb begin
    case (hburst)
      3'd2, 3'd3: burst_load = 4'd3;
      3'd4, 3'd5: burst_load = 4'd7;
      3'd6, 3'd7: burst_load = 4'd15;
      default:    burst_load = 4'd0;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (hready) begin
      case (htrans)
        TR_IDLE:   cnt_next = 4'd0;
        TR_BUSY:   cnt_next = cnt_reg;
        TR_NONSEQ: cnt_next = burst_load;
        TR_SEQ:    cnt_next = (cnt_reg != 4'd0) ? cnt_reg - 4'd1 : 4'd0;
        default:   cnt_next = cnt_reg;
      endcase
    end
  end

  assign locked_hold = hlock[owner_reg] & hbusreq[owner_reg];
  assign window      = hready & (cnt_next == 4'd0) & ~locked_hold;

  // Search upward from the slot after the last winner, wrapping modulo NM.
  always_comb begin
    rr_winner = DEF_IDX;
    rr_found  = 1'b0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int i = 1; i <= NM; i++) begin
      rr_sum = {1'b0, ptr_reg} + IW'(i);
      if (rr_sum >= IW'(NM)) rr_sum = rr_sum - IW'(NM);
      rr_idx = rr_sum[MW-1:0];
      if (!rr_found && hbusreq[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  always_comb begin
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    if (window && (rr_winner != owner_reg)) begin
      owner_next = rr_winner;
      ptr_next   = rr_winner;
    end
  end

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_grant
      assign grant_next[gi] = (owner_next == MW'(gi));
    end
  endgenerate

  // hmaster/hmastlock take the pre-edge owner, giving the one-cycle handover.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hgrant    <= DEF_GRANT;
      owner_reg <= DEF_IDX;
      ptr_reg   <= DEF_IDX;
      cnt_reg   <= 4'd0;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else if (hready) begin
      hgrant    <= grant_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      hmaster   <= owner_reg;
      hmastlock <= hlock[owner_reg];
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hburst = SINGLE;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state: current owner, last winner, beats still owed, registered outputs.
  int   m_owner, m_ptr, m_cnt, m_hmaster;
  logic m_lock;
  int   beats[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  ahb_rr_arbiter #(.NM(4), .DEFAULT_MASTER(0)) dut (
    .clk(clk), .rstn(rstn), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmastlock(hmastlock)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_cnt = 0; m_hmaster = 0; m_lock = 1'b0;
  endtask

  task automatic model_update();
    int nc;
    int w;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!hready) return;
    case (htrans)
      2'd0:    nc = 0;
      2'd1:    nc = m_cnt;
      2'd2:    nc = beats[hburst] - 1;
      default: nc = (m_cnt > 0) ? m_cnt - 1 : 0;
    endcase
    m_hmaster = m_owner;
    m_lock    = hlock[m_owner];
    if (nc == 0 && !(hlock[m_owner] && hbusreq[m_owner])) begin
      w = 0;
      for (int k = 1; k <= 4; k++) begin
        if (hbusreq[(m_ptr + k) % 4]) begin
          w = (m_ptr + k) % 4;
          break;
        end
      end
      if (w != m_owner) begin
        m_owner = w;
        m_ptr   = w;
      end
    end
    m_cnt = nc;
  endtask

  function automatic logic [3:0] m_grant();
    return 4'(1 << m_owner);
  endfunction

  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input logic [2:0] hb, input logic rdy);
    hbusreq = req; hlock = lk; htrans = tr; hburst = hb; hready = rdy;
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    $display("cyc=%0d req=%b lock=%b trans=%0d burst=%0d rdy=%b -> hgrant=%b hmaster=%0d hmastlock=%b",
             cyc, req, lk, tr, hb, rdy, hgrant, hmaster, hmastlock);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    rstn = 1'b1;
    step(4'b1110, 4'b0000, NONSEQ, INCR4, 1'b1);
    step(4'b1110, 4'b0000, SEQ, INCR4, 1'b1);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got hgrant=%b hmaster=%0d hmastlock=%b, expected 0001/0/0",
               hgrant, hmaster, hmastlock);
    end
    step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
      n_chk++;
      if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got hgrant=%b hmaster=%0d hmastlock=%b, expected 0001/0/0",
                 i, hgrant, hmaster, hmastlock);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] exp_m[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
      n_chk++;
      if (hgrant !== exp_g[i] || hmaster !== exp_m[i]) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got hgrant=%b hmaster=%0d, expected hgrant=%b hmaster=%0d",
                 i, hgrant, hmaster, exp_g[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_fixed_burst(input int waits);
    int n;
    int change_at;
    logic [3:0] exp_g;
    step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    n_chk++;
    if (hgrant !== 4'b0100) begin
      n_fail++;
      $display("FAIL burst_setup(w=%0d): got hgrant=%b, expected 0100", waits, hgrant);
    end
    n = 4 + waits;
    change_at = -1;
    for (int e = 0; e < n; e++) begin
      step(4'b0111, 4'b0000, (e == 0) ? NONSEQ : SEQ, INCR4,
           (e >= 2 && e < 2 + waits) ? 1'b0 : 1'b1);
      exp_g = (e == n - 1) ? 4'b0001 : 4'b0100;
      if (change_at < 0 && hgrant !== 4'b0100) change_at = e;
      n_chk++;
      if (hgrant !== exp_g || hmaster !== 2'd2) begin
        n_fail++;
        $display("FAIL burst_beat(w=%0d,e=%0d): got hgrant=%b hmaster=%0d, expected hgrant=%b hmaster=2",
                 waits, e, hgrant, hmaster, exp_g);
      end
    end
    n_chk++;
    if (change_at != 3 + waits) begin
      n_fail++;
      $display("FAIL burst_handover(w=%0d): got edge %0d, expected edge %0d", waits, change_at, 3 + waits);
    end
  endtask

  task automatic test_lock();
    step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 4'b0010, NONSEQ, SINGLE, 1'b1);
      n_chk++;
      if (hgrant !== 4'b0010 || hmastlock !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: got hgrant=%b hmastlock=%b, expected 0010/1", i, hgrant, hmastlock);
      end
    end
    step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
    n_chk++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0100, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_release: got hgrant=%b hmaster=%0d hmastlock=%b, expected 0100/1/0",
               hgrant, hmaster, hmastlock);
    end
  endtask

  task automatic test_early_term();
    logic [1:0] trs[3] = '{NONSEQ, SEQ, IDLE};
    logic [3:0] exp_g[3] = '{4'b0010, 4'b0010, 4'b1000};
    step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    n_chk++;
    if (hgrant !== 4'b0010) begin
      n_fail++;
      $display("FAIL early_setup: got hgrant=%b, expected 0010", hgrant);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 4'b0000, trs[i], INCR8, 1'b1);
      n_chk++;
      if (hgrant !== exp_g[i]) begin
        n_fail++;
        $display("FAIL early_term[%0d]: got hgrant=%b, expected %b", i, hgrant, exp_g[i]);
      end
    end
    step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    step(4'b1010, 4'b0000, NONSEQ, INCR, 1'b1);
    n_chk++;
    if (hgrant !== 4'b1000 || hmaster !== 2'd1) begin
      n_fail++;
      $display("FAIL incr_regrant: got hgrant=%b hmaster=%0d, expected 1000/1", hgrant, hmaster);
    end
  endtask

  task automatic test_random();
    logic [3:0] lk;
    #2 rstn = 1'b0;
    model_reset();
    #2 rstn = 1'b1;
    for (int i = 0; i < 500; i++) begin
      lk = '0;
      for (int b = 0; b < 4; b++) lk[b] = ($urandom_range(0, 7) == 0);
      step(4'($urandom_range(0, 15)), lk, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
      n_chk++;
      if ({hgrant, hmaster, hmastlock} !== {m_grant(), 2'(m_hmaster), m_lock} || !$onehot(hgrant)) begin
        n_fail++;
        $display("FAIL random[%0d]: got hgrant=%b hmaster=%0d hmastlock=%b, expected hgrant=%b hmaster=%0d hmastlock=%b",
                 i, hgrant, hmaster, hmastlock, m_grant(), m_hmaster, m_lock);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_fixed_burst(0);
    test_fixed_burst(3);
    test_lock();
    test_early_term();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
AHB bus arbiter that shares one AHB address/data path between NM masters, for example m0..m3 in front of the slave interconnect. It decides the owner with round-robin priority and honours fixed-length bursts and locked sequences. It drives one-hot hgrant, plus hmaster/hmastlock for the address/data muxes and slave decoder. Clocked from the same clk as the AHB interfaces.

Parameters:
NM, 4, number of masters (2..16)
DEFAULT_MASTER, 0, master granted when nobody requests
MW, $clog2(NM), width of hmaster

Ports:
clk  in  1  system clock (AHB HCLK)
rstn  in  1  asynchronous active-low reset
hbusreq  in  NM  per-master bus request
hlock  in  NM  per-master lock request
htrans  in  2  HTRANS of current address-phase owner (muxed by hmaster)
hburst  in  3  HBURST of current address-phase owner
hready  in  1  bus HREADY
hgrant  out  NM  one-hot grant, registered
hmaster  out  MW  index of address-phase owner, registered
hmastlock  out  1  current transfer is locked, registered

Behaviour:
- Reset (async, rstn=0), values take effect immediately:
  - hgrant = 1<<DEFAULT_MASTER
  - hmaster = DEFAULT_MASTER
  - hmastlock = 0
  - beat counter cnt = 0
  - last-winner pointer = DEFAULT_MASTER
- Reset asserted mid-burst abandons the burst. There is no recovery state.
- htrans encoding: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3. "Accepted" means hready=1 at the posedge.
- Beat counter:
  - Accepted NONSEQ with hburst INCR4/WRAP4 loads 3, INCR8/WRAP8 loads 7, INCR16/WRAP16 loads 15, SINGLE/INCR loads 0.
  - Accepted SEQ with cnt>0: cnt-1.
  - BUSY: hold.
  - Accepted IDLE: cnt=0 (early termination).
  - Accepted NONSEQ while cnt>0: reload (new burst).
- cnt_next is the counter value after this cycle's update.
- Arbitration window: the posedge where hready=1 and cnt_next==0 and not locked_hold.
  - locked_hold = hlock[granted index]=1 while that master still requests.
- Winner:
  - Round-robin over hbusreq, searching from (last winner+1) mod NM upward, wrapping.
  - No requests: DEFAULT_MASTER.
  - Winner equals current owner: grant unchanged, pointer unchanged.
  - Otherwise the pointer updates to the winner.
- Outside a window, hgrant holds, including when the owner drops hbusreq mid fixed burst.
- INCR (undefined length): every accepted beat is a window, so the owner loses the bus to another requester at the next beat.
- hmaster <= index(hgrant) at every posedge with hready=1.
  - This gives a 1-cycle handover: grant in cycle N, the new master drives NONSEQ in N+1 with hmaster updated.
- hmastlock <= hlock[index(hgrant)] at the same hready edges.
- hready=0 freezes hgrant, hmaster, hmastlock and cnt.
- hgrant is always exactly one-hot. hmaster is never out of range.
- Requests changing during hready=0 are sampled only at the next window.

Test Plan:
- Reset: rstn=0 mid-activity -> hgrant=0001, hmaster=0, hmastlock=0 immediately. After release with no requests, these stay unchanged.
- Round-robin: hbusreq=1111, SINGLE transfers, hready=1 -> grant sequence m1,m2,m3,m0,m1. hmaster follows one cycle later.
- Fixed burst: m2 granted, issues INCR4 (NONSEQ+3 SEQ) while m0/m1 request -> hgrant stays 0100 until the 3rd SEQ edge. m3 is not requesting, so the round-robin search wraps and the next grant goes to m0 (0001).
- Wait states: during that burst hold hready=0 for 3 cycles -> hgrant, hmaster and cnt frozen. The handover is delayed by exactly 3 cycles.
- Lock: m1 holds hlock=1 and hbusreq=1 across 3 SINGLE transfers with others requesting -> hgrant=0010 throughout and hmastlock=1. Dropping hlock releases the grant at the next window.
- Early termination and INCR: INCR8 interrupted by accepted IDLE after 2 beats -> cnt=0 and regrant at that edge. INCR with m3 also requesting -> m3 granted after the first accepted beat.
